seven_seg_scanner: RTL

Parametrised N-digit multiplexed seven-segment driver. It is the successor to the two-digit display driver and sits between the counter/datapath logic and the board's common-anode display. It adds a configurable digit count, frame-synchronous input latching, per-digit blanking and decimal points, and leading-zero suppression. It also adds optional hex glyphs, anti-ghosting guard time and 16-level PWM brightness.

---
 rtl/seven_seg_scanner.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scanner
// Brief    : N-digit multiplexed seven-segment driver for a common-anode
//            display. Frame-synchronous input shadowing, per-digit blanking
//            and decimal points, leading-zero suppression, optional hex
//            glyphs, anti-ghosting guard time and 16-level PWM brightness.
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_scanner #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 100000,
    parameter int GUARD    = 2,
    parameter int HEX      = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  lzs,
    input  logic [3:0]            brightness,
    output logic [6:0]            seven_seg_cathod,
    output logic                  seven_seg_dp,
    output logic [DIGITS-1:0]     seven_seg_anode,
    output logic                  frame_done
);

    localparam int c_DW_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_DW_W-1:0]  c_DW_LAST  = c_DW_W'(TICK_DIV - 1);
    localparam logic [c_DW_W-1:0]  c_DW_GUARD = c_DW_W'(GUARD);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DIGITS - 1);
    localparam logic [6:0]         c_SEG_OFF  = 7'b1111111;

    // Scan counters
    logic [c_DW_W-1:0]  dwell_q, dwell_d;
    logic [c_IDX_W-1:0] idx_q, idx_d;
    logic [3:0]         pwm_q, pwm_d;

    // Frame-synchronous shadows of the inputs
    logic [4*DIGITS-1:0] dig_q;
    logic [DIGITS-1:0]   dp_q;
    logic [DIGITS-1:0]   blank_q;
    logic                lzs_q;
    logic [3:0]          bright_q;

    // Registered outputs
    logic [6:0]          cath_q, cath_d;
    logic                dp_out_q, dp_out_d;
    logic [DIGITS-1:0]   anode_q, anode_d;
    logic                fdone_q, fdone_d;

    // Combinational helpers
    logic                w_load;
    logic [DIGITS-1:0]   w_eff_blank;
    logic [3:0]          w_code_sel;
    logic                w_dp_sel;
    logic                w_blank_sel;
    logic                w_lit;

    // Active-low glyph for a 4-bit code; codes above 9 depend on HEX
    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] seg;
        seg = 7'b0111111;
        case (code)
            4'd0:  seg = 7'b1000000;
            4'd1:  seg = 7'b1111001;
            4'd2:  seg = 7'b0100100;
            4'd3:  seg = 7'b0110000;
            4'd4:  seg = 7'b0011001;
            4'd5:  seg = 7'b0010010;
            4'd6:  seg = 7'b0000010;
            4'd7:  seg = 7'b1111000;
            4'd8:  seg = 7'b0000000;
            4'd9:  seg = 7'b0010000;
            4'd10: seg = (HEX != 0) ? 7'b0001000 : 7'b0111111;
            4'd11: seg = (HEX != 0) ? 7'b0000011 : 7'b0111111;
            4'd12: seg = (HEX != 0) ? 7'b1000110 : 7'b0111111;
            4'd13: seg = (HEX != 0) ? 7'b0100001 : 7'b0111111;
            4'd14: seg = (HEX != 0) ? 7'b0000110 : 7'b0111111;
            4'd15: seg = (HEX != 0) ? 7'b0001110 : 7'b0111111;
            default: seg = 7'b0111111;
        endcase
        return seg;
    endfunction

    // Dwell/index/PWM advance; shadows reload at the very start of a frame
    always_comb begin
        dwell_d = dwell_q + c_DW_W'(1);
        idx_d   = idx_q;
        pwm_d   = pwm_q + 4'd1;
        if (dwell_q == c_DW_LAST) begin
            dwell_d = '0;
            idx_d   = (idx_q == c_IDX_LAST) ? '0 : idx_q + c_IDX_W'(1);
        end
        w_load = (dwell_q == '0) && (idx_q == '0);
    end

    // Effective blanking: walk from the MSB down while the run of zeros lasts
    always_comb begin
        logic run;
        logic zero;
        run         = 1'b1;
        zero        = 1'b0;
        w_eff_blank = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero           = (dig_q[4*i +: 4] == 4'd0);
            w_eff_blank[i] = blank_q[i] | ((i != 0) & lzs_q & run & zero);
            run            = run & zero & ~blank_q[i];
        end
    end

    // Select the current digit's code, dp and blank
    always_comb begin
        w_code_sel  = 4'd0;
        w_dp_sel    = 1'b0;
        w_blank_sel = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == c_IDX_W'(i)) begin
                w_code_sel  = dig_q[4*i +: 4];
                w_dp_sel    = dp_q[i];
                w_blank_sel = w_eff_blank[i];
            end
        end
    end

    // Next output values; everything dark unless the selected digit is lit
    always_comb begin
        w_lit    = (dwell_q >= c_DW_GUARD) && (pwm_q < bright_q) && !w_blank_sel;
        anode_d  = '1;
        cath_d   = c_SEG_OFF;
        dp_out_d = 1'b1;
        if (w_lit) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (idx_q == c_IDX_W'(i)) begin
                    anode_d[i] = 1'b0;
                end
            end
            cath_d   = decode(w_code_sel);
            dp_out_d = ~w_dp_sel;
        end
        fdone_d = (dwell_q == c_DW_LAST) && (idx_q == c_IDX_LAST);
    end

    // State, shadow and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            dwell_q  <= '0;
            idx_q    <= '0;
            pwm_q    <= 4'd0;
            dig_q    <= '0;
            dp_q     <= '0;
            blank_q  <= '1;
            lzs_q    <= 1'b0;
            bright_q <= 4'd0;
            cath_q   <= c_SEG_OFF;
            dp_out_q <= 1'b1;
            anode_q  <= '1;
            fdone_q  <= 1'b0;
        end else begin
            dwell_q  <= dwell_d;
            idx_q    <= idx_d;
            pwm_q    <= pwm_d;
            if (w_load) begin
                dig_q    <= digits_in;
                dp_q     <= dp_in;
                blank_q  <= blank_in;
                lzs_q    <= lzs;
                bright_q <= brightness;
            end
            cath_q   <= cath_d;
            dp_out_q <= dp_out_d;
            anode_q  <= anode_d;
            fdone_q  <= fdone_d;
        end
    end

    assign seven_seg_cathod = cath_q;
    assign seven_seg_dp     = dp_out_q;
    assign seven_seg_anode  = anode_q;
    assign frame_done       = fdone_q;

endmodule
`default_nettype wire
